// File: rtl/crack_job_manager_pkg.sv
// crack_job_manager_pkg: state encoding and frame constants shared by the job manager
package crack_job_manager_pkg;
   typedef enum logic [1:0] {LOAD, RUN, SEND} state_t;
   localparam logic [4:0] JOB_BYTES = 5'd18;
   localparam logic [4:0] RESULT_BYTES = 5'd17;
   localparam logic [7:0] STATUS_FOUND = 8'h01;
   localparam logic [7:0] STATUS_NOT_FOUND = 8'h00;
endpackage

// File: rtl/crack_job_manager_result_serializer.sv
// result_serializer: emits a status byte then up to 16 payload bytes MSB first over valid/ready
module result_serializer (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [7:0]   status,
   input  logic [127:0] payload,
   input  logic [4:0]   nbytes,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         done
);
   logic [127:0] sh;
   logic [4:0]   rem;
   logic         fire;
   assign out_valid = rem != 5'd0;
   assign fire = out_valid && out_ready;
   assign done = fire && rem == 5'd1;
   // present the status byte on load, then shift the next payload byte in on each accepted byte
   always_ff @(posedge clk) begin
      if (rst) begin
         sh <= '0;
         rem <= '0;
         out_data <= '0;
      end else if (load) begin
         out_data <= status;
         sh <= payload;
         rem <= nbytes;
      end else if (fire) begin
         out_data <= sh[127:120];
         sh <= {sh[119:0], 8'h00};
         rem <= rem - 5'd1;
      end
   end
endmodule

// File: rtl/crack_job_manager.sv
// crack_job_manager: loads an 18-byte crack job, runs the MD5 controller, reports the result
module crack_job_manager
   import crack_job_manager_pkg::*;
#(
   parameter logic [31:0] MAX_CANDIDATES = 32'd1000000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [7:0]   in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_data,
   output logic         ctl_run,
   output logic [7:0]   ctl_start,
   output logic [2:0]   ctl_increment,
   output logic [127:0] ctl_target_hash,
   input  logic         ctl_enable,
   input  logic         ctl_hashes_equal,
   input  logic [127:0] ctl_plaintext
);
   state_t      state, state_nxt;
   logic [4:0]  in_idx;
   logic [31:0] cnt;
   logic        in_fire, last_in, hit, exhaust, ser_load, ser_done;
   assign in_ready = state == LOAD;
   assign ctl_run = state == RUN;
   assign in_fire = in_valid && in_ready;
   assign last_in = in_fire && in_idx == JOB_BYTES - 5'd1;
   assign hit = ctl_run && ctl_enable && ctl_hashes_equal;
   assign exhaust = ctl_run && ctl_enable && cnt + 32'd1 >= MAX_CANDIDATES;
   assign ser_load = hit || exhaust;
   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= LOAD;
      else state <= state_nxt;
   end
   // next state: each transition qualifier is only ever true in its own state
   always_comb begin
      state_nxt = state;
      state_nxt = (state == LOAD && last_in)  ? RUN  :
                  (state == RUN  && ser_load) ? SEND :
                  (state == SEND && ser_done) ? LOAD : state;
   end
   // job frame capture: start, increment, then hash shifted in MSB byte first
   always_ff @(posedge clk) begin
      if (rst) begin
         in_idx <= '0;
         ctl_start <= '0;
         ctl_increment <= '0;
         ctl_target_hash <= '0;
      end else if (in_fire) begin
         in_idx <= last_in ? 5'd0 : in_idx + 5'd1;
         if (in_idx == 5'd0) ctl_start <= in_data;
         if (in_idx == 5'd1) ctl_increment <= in_data[2:0];
         if (in_idx >= 5'd2) ctl_target_hash <= {ctl_target_hash[119:0], in_data};
      end
   end
   // candidate counter: cleared as a job starts, counts controller-valid cycles while running
   always_ff @(posedge clk) begin
      if (rst || last_in) cnt <= '0;
      else if (ctl_run && ctl_enable) cnt <= cnt + 32'd1;
   end
   result_serializer u_ser (
      .clk      (clk),
      .rst      (rst),
      .load     (ser_load),
      .status   (hit ? STATUS_FOUND : STATUS_NOT_FOUND),
      .payload  (hit ? ctl_plaintext : 128'd0),
      .nbytes   (hit ? RESULT_BYTES : 5'd1),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .done     (ser_done)
   );
endmodule

// File: tb/tb_crack_job_manager.sv
// tb_crack_job_manager: scoreboard bench with a behavioural MD5 controller model
module tb_crack_job_manager;
   logic clk = 0, rst = 1, sel = 0;
   logic in_valid = 0, out_ready = 0, ctl_enable = 0, ctl_hashes_equal = 0;
   logic [7:0] in_data = 0;
   logic [127:0] ctl_plaintext = 0;
   logic in_ready_a, out_valid_a, ctl_run_a, in_ready_b, out_valid_b, ctl_run_b;
   logic [7:0] out_data_a, ctl_start_a, out_data_b, ctl_start_b;
   logic [2:0] ctl_increment_a, ctl_increment_b;
   logic [127:0] ctl_target_hash_a, ctl_target_hash_b;
   logic in_ready, out_valid, ctl_run;
   logic [7:0] out_data, ctl_start;
   logic [2:0] ctl_increment;
   logic [127:0] ctl_target_hash;
   int checks = 0, failures = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   crack_job_manager dut_a (
      .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(in_ready_a), .in_data(in_data),
      .out_valid(out_valid_a), .out_ready(out_ready && !sel), .out_data(out_data_a),
      .ctl_run(ctl_run_a), .ctl_start(ctl_start_a), .ctl_increment(ctl_increment_a),
      .ctl_target_hash(ctl_target_hash_a), .ctl_enable(ctl_enable),
      .ctl_hashes_equal(ctl_hashes_equal), .ctl_plaintext(ctl_plaintext)
   );

   crack_job_manager #(.MAX_CANDIDATES(32'd8)) dut_b (
      .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(in_ready_b), .in_data(in_data),
      .out_valid(out_valid_b), .out_ready(out_ready && sel), .out_data(out_data_b),
      .ctl_run(ctl_run_b), .ctl_start(ctl_start_b), .ctl_increment(ctl_increment_b),
      .ctl_target_hash(ctl_target_hash_b), .ctl_enable(ctl_enable),
      .ctl_hashes_equal(ctl_hashes_equal), .ctl_plaintext(ctl_plaintext)
   );

   assign in_ready = sel ? in_ready_b : in_ready_a;
   assign out_valid = sel ? out_valid_b : out_valid_a;
   assign out_data = sel ? out_data_b : out_data_a;
   assign ctl_run = sel ? ctl_run_b : ctl_run_a;
   assign ctl_start = sel ? ctl_start_b : ctl_start_a;
   assign ctl_increment = sel ? ctl_increment_b : ctl_increment_a;
   assign ctl_target_hash = sel ? ctl_target_hash_b : ctl_target_hash_a;

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] want);
      checks++;
      if (act !== want) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, want);
      end
   endtask

   task automatic push_result(input bit found, input logic [127:0] pt);
      exp_q.push_back(found ? 8'h01 : 8'h00);
      if (found) for (int i = 15; i >= 0; i--) exp_q.push_back(pt[i*8 +: 8]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1;
      repeat (2) @(negedge clk);
      rst = 0;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_ctl_run", ctl_run, 0);
      chk("rst_ctl_start", ctl_start, 0);
      chk("rst_ctl_increment", ctl_increment, 0);
      chk("rst_ctl_target_hash", ctl_target_hash, 0);
   endtask

   task automatic send_job(input logic [7:0] start, input logic [7:0] inc, input logic [127:0] hash, input int nbytes);
      logic [7:0] b;
      for (int i = 0; i < nbytes; i++) begin
         @(negedge clk);
         if (i == 0) b = start;
         else if (i == 1) b = inc;
         else b = hash[8*(17-i) +: 8];
         in_valid = 1;
         in_data = b;
         if (i == 0) chk("load_in_ready", in_ready, 1);
         if (i == 17) chk("run_before_last", ctl_run, 0);
      end
      @(negedge clk);
      in_valid = 0;
      if (nbytes == 18) chk("run_after_last", ctl_run, 1);
   endtask

   task automatic run_ctl(input int match_at, input bit gap, input bit spurious, input logic [127:0] pt,
                          input int want_cand, input bit probe);
      int cand = 0, cyc = 0;
      bit en, hitnow;
      while (ctl_run && cyc < 400) begin
         en = !gap || (cyc % 2 == 1);
         hitnow = en && (cand + 1 == match_at);
         ctl_enable = en;
         ctl_hashes_equal = en ? hitnow : spurious;
         ctl_plaintext = hitnow ? pt : {$urandom, $urandom, $urandom, $urandom};
         if (en) cand++;
         if (probe && cyc == 1) begin
            in_valid = 1;
            in_data = 8'hAA;
            chk("run_in_ready", in_ready, 0);
         end
         cyc++;
         @(negedge clk);
      end
      ctl_enable = 0;
      ctl_hashes_equal = 0;
      in_valid = 0;
      chk("cand_count", cand, want_cand);
      chk("run_dropped", ctl_run, 0);
      chk("valid_on_send", out_valid, 1);
   endtask

   task automatic drain(input int stall_at);
      int k = 0, guard = 0, stall = 5;
      while (exp_q.size() > 0 && guard < 300) begin
         @(negedge clk);
         guard++;
         if (!out_valid) out_ready = 0;
         else if (k == stall_at && stall > 0) begin
            out_ready = 0;
            stall--;
            chk("stall_hold", out_data, exp_q[0]);
         end else begin
            out_ready = 1;
            chk($sformatf("out_byte%0d", k), out_data, exp_q.pop_front());
            k++;
         end
      end
      chk("drain_left", exp_q.size(), 0);
      @(negedge clk);
      out_ready = 0;
      chk("ready_after_send", in_ready, 1);
      chk("valid_after_send", out_valid, 0);
   endtask

   initial begin
      logic [127:0] pt_vader, pt2, pt4, pt5;
      pt_vader = {88'h0, 40'h7661646572};
      pt2 = 128'h00112233445566778899aabbccddeeff;
      pt4 = 128'hcafef00d_0badbeef_12345678_9abcdef0;
      pt5 = 128'h6a656469_00000000_00000000_00000000;
      do_reset();
      push_result(1, pt_vader);
      send_job(8'h61, 8'h01, 128'h2db1850a4fe292bd2706ffd78dbe44b9, 18);
      chk("a_start", ctl_start, 8'h61);
      chk("a_inc", ctl_increment, 3'd1);
      chk("a_hash", ctl_target_hash, 128'h2db1850a4fe292bd2706ffd78dbe44b9);
      run_ctl(40, 0, 0, pt_vader, 40, 0);
      drain(-1);
      push_result(1, pt2);
      send_job(8'h30, 8'hFE, 128'hfeedface_01020304_a5a5a5a5_5a5a5a5a, 18);
      chk("b_inc", ctl_increment, 3'b110);
      run_ctl(5, 1, 0, pt2, 5, 0);
      drain(3);
      chk("fields_held", ctl_start, 8'h30);
      sel = 1;
      push_result(0, '0);
      send_job(8'h41, 8'h02, 128'h0f0e0d0c_0b0a0908_07060504_03020100, 18);
      run_ctl(0, 0, 0, '0, 8, 0);
      drain(-1);
      push_result(1, pt4);
      send_job(8'h7a, 8'h07, 128'h11111111_22222222_33333333_44444444, 18);
      run_ctl(8, 1, 1, pt4, 8, 0);
      drain(-1);
      send_job(8'h21, 8'h01, 128'h99, 18);
      run_ctl(2, 0, 0, pt2, 2, 0);
      do_reset();
      out_ready = 1;
      repeat (3) @(negedge clk);
      chk("no_stale_out", out_valid, 0);
      out_ready = 0;
      sel = 0;
      send_job(8'h11, 8'h05, 128'hdeadbeef_deadbeef_deadbeef_deadbeef, 10);
      do_reset();
      push_result(1, pt5);
      send_job(8'h62, 8'h03, 128'h0123456789abcdef_fedcba9876543210, 18);
      chk("c_start", ctl_start, 8'h62);
      chk("c_inc", ctl_increment, 3'd3);
      chk("c_hash", ctl_target_hash, 128'h0123456789abcdef_fedcba9876543210);
      run_ctl(3, 0, 0, pt5, 3, 1);
      chk("c_start_after_run", ctl_start, 8'h62);
      drain(-1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
